// File: rtl/fetch_arbiter_if.sv
// Memory port, decode handshake and CPU data port of the fetch arbiter.
// master = arbiter side, slave = memory/CPU side.
interface fetch_arbiter_if;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [15:0] d_rdata;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata,
      output instr_valid, instr, instr_pc,
      input  instr_ready, redirect, redirect_pc,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata,
      input  instr_valid, instr, instr_pc,
      output instr_ready, redirect, redirect_pc,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata
   );
endinterface

// File: rtl/fetch_arbiter.sv
// Owns the single memory port: sequential instruction prefetch into a small FIFO,
// with CPU data loads/stores taking priority and PC redirect flushing stale fetches.
module fetch_arbiter #(
   parameter logic [15:0] RESET_PC = 16'd0,
   parameter int          DEPTH    = 2
) (
   input logic             CLK,
   input logic             reset,
   fetch_arbiter_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IF_NONE, IF_DATA, IF_FETCH} inflight_t;

   inflight_t   r_inflight, w_next_inflight;
   logic [15:0] r_pc;
   logic        r_epoch;
   logic        r_tag_epoch;
   logic [15:0] r_tag_pc;
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_count;
   logic [15:0] r_q_instr [DEPTH];
   logic [15:0] r_q_pc    [DEPTH];
   logic [15:0] r_d_rdata;

   logic        w_pop, w_push, w_room, w_issue;
   logic        w_mem_read, w_mem_write, w_gnt;
   logic [15:0] w_mem_addr, w_mem_wdata;

   // A redirect flush wins over a same-cycle pop.
   assign w_pop  = (r_count != '0) && bus.instr_ready && !bus.redirect;
   assign w_push = (r_inflight == IF_FETCH) && (r_tag_epoch == r_epoch) && !bus.redirect;
   // Reserve a slot for every outstanding fetch; a departing head frees its slot this
   // cycle, which keeps streaming at one word per cycle without ever overfilling.
   assign w_room = (int'(r_count) - int'(w_pop) + int'(r_inflight == IF_FETCH)) < DEPTH;

   always_comb begin
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_mem_addr      = r_pc;
      w_mem_wdata     = 16'h0000;
      w_gnt           = 1'b0;
      w_issue         = 1'b0;
      w_next_inflight = IF_NONE;
      if (bus.d_req) begin
         w_gnt      = 1'b1;
         w_mem_addr = bus.d_addr;
         if (bus.d_we) begin
            w_mem_write = 1'b1;
            w_mem_wdata = bus.d_wdata;
         end else begin
            w_mem_read      = 1'b1;
            w_next_inflight = IF_DATA;
         end
      end else if (!bus.redirect && w_room) begin
         w_mem_read      = 1'b1;
         w_issue         = 1'b1;
         w_next_inflight = IF_FETCH;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_inflight  <= IF_NONE;
         r_pc        <= RESET_PC;
         r_epoch     <= 1'b0;
         r_tag_epoch <= 1'b0;
         r_tag_pc    <= 16'h0000;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_d_rdata   <= 16'h0000;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= 16'h0000;
            r_q_pc[i]    <= 16'h0000;
         end
      end else begin
         r_inflight <= w_next_inflight;
         if (r_inflight == IF_DATA) r_d_rdata <= bus.mem_rdata;
         if (w_issue) begin
            r_tag_pc    <= r_pc;
            r_tag_epoch <= r_epoch;
            r_pc        <= r_pc + 16'd1;
         end
         if (bus.redirect) begin
            r_pc     <= bus.redirect_pc;
            r_epoch  <= ~r_epoch;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_q_instr[r_wr_ptr] <= bus.mem_rdata;
               r_q_pc[r_wr_ptr]    <= r_tag_pc;
               r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end
      end
   end

   assign bus.mem_read    = reset & w_mem_read;
   assign bus.mem_write   = reset & w_mem_write;
   assign bus.mem_addr    = w_mem_addr;
   assign bus.mem_wdata   = w_mem_wdata;
   assign bus.d_gnt       = reset & w_gnt;
   assign bus.instr_valid = (r_count != '0);
   assign bus.instr       = r_q_instr[r_rd_ptr];
   assign bus.instr_pc    = r_q_pc[r_rd_ptr];
   assign bus.d_rvalid    = (r_inflight == IF_DATA);
   assign bus.d_rdata     = (r_inflight == IF_DATA) ? bus.mem_rdata : r_d_rdata;
endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: vector table for the streaming/data-priority case,
// hand sequences for backpressure, redirect, PC wrap, store/load and async reset.
module tb_fetch_arbiter;
   logic CLK = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   fetch_arbiter_if bus ();

   fetch_arbiter #(.RESET_PC(16'd0), .DEPTH(2)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // 1024x16 synchronous-read memory; unwritten words read as A000+index, word 25 is zero
   logic [15:0]   store_q [1024];
   logic [1023:0] written = '0;
   logic [15:0]   rd_q = 16'h0000;

   function automatic logic [15:0] init_word(input logic [9:0] a);
      return (a == 10'd25) ? 16'h0000 : (16'hA000 + {6'd0, a});
   endfunction

   always @(posedge CLK) begin
      if (bus.mem_write) begin
         store_q[bus.mem_addr[9:0]] <= bus.mem_wdata;
         written[bus.mem_addr[9:0]] <= 1'b1;
      end
      if (bus.mem_read)
         rd_q <= written[bus.mem_addr[9:0]] ? store_q[bus.mem_addr[9:0]]
                                            : init_word(bus.mem_addr[9:0]);
   end
   assign bus.mem_rdata = rd_q;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.d_req       = 1'b0;
      bus.d_we        = 1'b0;
      bus.d_addr      = 16'h0000;
      bus.d_wdata     = 16'h0000;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
   endtask

   // Leaves the bench at posedge+1 of cycle 0 with reset released.
   task automatic do_reset(input logic rdy);
      reset = 1'b0;
      idle_inputs();
      bus.instr_ready = rdy;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      reset = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic        rdy;
      logic        dreq;
      logic [15:0] daddr;
      logic        e_rd;
      logic [15:0] e_addr;
      logic        e_gnt;
      logic        e_vld;
      logic [15:0] e_instr;
      logic [15:0] e_ipc;
      logic        e_rv;
      logic [15:0] e_rdata;
   } vec_t;

   vec_t vecs [9];

   initial begin
      reset = 1'b0;
      bus.instr_ready = 1'b0;
      idle_inputs();

      //            rdy   dreq  daddr   rd    addr    gnt   vld   instr     ipc     rv    rdata
      vecs[0] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd0,  1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd1,  1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd2,  1'b0, 1'b1, 16'hA000, 16'd0, 1'b0, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd3,  1'b0, 1'b1, 16'hA001, 16'd1, 1'b0, 16'h0000};
      vecs[4] = '{1'b1, 1'b1, 16'd25, 1'b1, 16'd25, 1'b1, 1'b1, 16'hA002, 16'd2, 1'b0, 16'h0000};
      vecs[5] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd4,  1'b0, 1'b1, 16'hA003, 16'd3, 1'b1, 16'h0000};
      vecs[6] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd5,  1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 16'h0000};
      vecs[7] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd6,  1'b0, 1'b1, 16'hA004, 16'd4, 1'b0, 16'h0000};
      vecs[8] = '{1'b1, 1'b0, 16'd0,  1'b1, 16'd7,  1'b0, 1'b1, 16'hA005, 16'd5, 1'b0, 16'h0000};

      // Reset state while held low
      #2;
      chk("rst.vld",   {15'd0, bus.instr_valid}, 16'd0);
      chk("rst.rd",    {15'd0, bus.mem_read},    16'd0);
      chk("rst.rvld",  {15'd0, bus.d_rvalid},    16'd0);

      // Streaming with a load interjected at cycle 4
      do_reset(1'b1);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) next_cycle();
         bus.instr_ready = vecs[i].rdy;
         bus.d_req       = vecs[i].dreq;
         bus.d_we        = 1'b0;
         bus.d_addr      = vecs[i].daddr;
         #1;
         chk($sformatf("v%0d.rd", i),    {15'd0, bus.mem_read},    {15'd0, vecs[i].e_rd});
         chk($sformatf("v%0d.wr", i),    {15'd0, bus.mem_write},   16'd0);
         chk($sformatf("v%0d.gnt", i),   {15'd0, bus.d_gnt},       {15'd0, vecs[i].e_gnt});
         chk($sformatf("v%0d.vld", i),   {15'd0, bus.instr_valid}, {15'd0, vecs[i].e_vld});
         chk($sformatf("v%0d.rv", i),    {15'd0, bus.d_rvalid},    {15'd0, vecs[i].e_rv});
         chk($sformatf("v%0d.rdata", i), bus.d_rdata,              vecs[i].e_rdata);
         if (vecs[i].e_rd)
            chk($sformatf("v%0d.addr", i), bus.mem_addr, vecs[i].e_addr);
         if (vecs[i].e_vld) begin
            chk($sformatf("v%0d.instr", i), bus.instr,    vecs[i].e_instr);
            chk($sformatf("v%0d.ipc", i),   bus.instr_pc, vecs[i].e_ipc);
         end
      end

      // Backpressure: exactly DEPTH reads, head held stable until ready
      do_reset(1'b0);
      #1;
      chk("bp.c0.rd",   {15'd0, bus.mem_read}, 16'd1);
      chk("bp.c0.addr", bus.mem_addr,          16'd0);
      next_cycle(); #1;
      chk("bp.c1.rd",   {15'd0, bus.mem_read}, 16'd1);
      chk("bp.c1.addr", bus.mem_addr,          16'd1);
      for (int c = 2; c < 4; c++) begin
         next_cycle(); #1;
         chk($sformatf("bp.c%0d.rd", c),    {15'd0, bus.mem_read},    16'd0);
         chk($sformatf("bp.c%0d.vld", c),   {15'd0, bus.instr_valid}, 16'd1);
         chk($sformatf("bp.c%0d.instr", c), bus.instr,                16'hA000);
         chk($sformatf("bp.c%0d.ipc", c),   bus.instr_pc,             16'd0);
      end
      next_cycle();
      bus.instr_ready = 1'b1;
      #1;
      chk("bp.c4.rd",    {15'd0, bus.mem_read}, 16'd1);
      chk("bp.c4.addr",  bus.mem_addr,          16'd2);
      chk("bp.c4.instr", bus.instr,             16'hA000);
      next_cycle(); #1;
      chk("bp.c5.instr", bus.instr,    16'hA001);
      chk("bp.c5.ipc",   bus.instr_pc, 16'd1);

      // Redirect while addr 1 is in flight and the FIFO holds addr 0
      do_reset(1'b0);
      next_cycle();
      next_cycle();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'd9;
      #1;
      chk("redir.rd", {15'd0, bus.mem_read}, 16'd0);
      next_cycle();
      bus.redirect    = 1'b0;
      bus.instr_ready = 1'b1;
      #1;
      chk("redir.c3.vld",  {15'd0, bus.instr_valid}, 16'd0);
      chk("redir.c3.rd",   {15'd0, bus.mem_read},    16'd1);
      chk("redir.c3.addr", bus.mem_addr,             16'd9);
      next_cycle(); #1;
      chk("redir.c4.vld",  {15'd0, bus.instr_valid}, 16'd0);
      chk("redir.c4.addr", bus.mem_addr,             16'd10);
      next_cycle(); #1;
      chk("redir.c5.vld",   {15'd0, bus.instr_valid}, 16'd1);
      chk("redir.c5.instr", bus.instr,                16'hA009);
      chk("redir.c5.ipc",   bus.instr_pc,             16'd9);

      // PC wrap from FFFF to 0000
      next_cycle();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      next_cycle();
      bus.redirect = 1'b0;
      #1;
      chk("wrap.addr0", bus.mem_addr, 16'hFFFF);
      next_cycle(); #1;
      chk("wrap.rd1",   {15'd0, bus.mem_read}, 16'd1);
      chk("wrap.addr1", bus.mem_addr,          16'h0000);
      next_cycle(); #1;
      chk("wrap.instr", bus.instr,    16'hA3FF);
      chk("wrap.ipc",   bus.instr_pc, 16'hFFFF);
      next_cycle(); #1;
      chk("wrap.instr2", bus.instr,    16'hA000);
      chk("wrap.ipc2",   bus.instr_pc, 16'h0000);

      // Store then load with the FIFO full (no fetch competing)
      do_reset(1'b0);
      next_cycle(); next_cycle(); next_cycle();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 16'd30;
      bus.d_wdata = 16'h1234;
      #1;
      chk("st.wr",    {15'd0, bus.mem_write}, 16'd1);
      chk("st.rd",    {15'd0, bus.mem_read},  16'd0);
      chk("st.gnt",   {15'd0, bus.d_gnt},     16'd1);
      chk("st.addr",  bus.mem_addr,           16'd30);
      chk("st.wdata", bus.mem_wdata,          16'h1234);
      next_cycle();
      bus.d_we = 1'b0;
      #1;
      chk("ld.rd",   {15'd0, bus.mem_read},  16'd1);
      chk("ld.wr",   {15'd0, bus.mem_write}, 16'd0);
      chk("ld.addr", bus.mem_addr,           16'd30);
      chk("ld.rv0",  {15'd0, bus.d_rvalid},  16'd0);
      next_cycle();
      bus.d_req = 1'b0;
      #1;
      chk("ld.rv1",    {15'd0, bus.d_rvalid}, 16'd1);
      chk("ld.rdata",  bus.d_rdata,           16'h1234);
      next_cycle(); #1;
      chk("ld.rv2",    {15'd0, bus.d_rvalid}, 16'd0);
      chk("ld.hold",   bus.d_rdata,           16'h1234);

      // Async reset mid-cycle with a request pending
      next_cycle();
      bus.d_req = 1'b1;
      #1;
      chk("ar.pre.gnt", {15'd0, bus.d_gnt}, 16'd1);
      reset = 1'b0;
      #1;
      chk("ar.rd",    {15'd0, bus.mem_read},    16'd0);
      chk("ar.wr",    {15'd0, bus.mem_write},   16'd0);
      chk("ar.gnt",   {15'd0, bus.d_gnt},       16'd0);
      chk("ar.vld",   {15'd0, bus.instr_valid}, 16'd0);
      chk("ar.instr", bus.instr,                16'h0000);
      chk("ar.ipc",   bus.instr_pc,             16'h0000);
      chk("ar.rv",    {15'd0, bus.d_rvalid},    16'd0);
      chk("ar.rdata", bus.d_rdata,              16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
